fetch_prefetch: RTL and testbench

Parametrised prefetching fetch unit for the LC3 datapath, the successor to the single-register fetch stage. It owns the fetch PC, keeps up to DEPTH instructions ahead of decode in a small queue, and talks to instruction memory through a req/ack handshake that tolerates variable latency. A taken branch flushes the queue and redirects the fetch PC; a response that was already in flight when the branch arrived is discarded.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 58 +++++
 rtl/fetch_prefetch.sv | 120 ++++++++++++
 tb/tb_fetch_prefetch.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the LC3 prefetching fetch unit.
package fetch_pkg;

  localparam int unsigned LC3_AW = 16;
  localparam int unsigned LC3_DW = 16;
  localparam logic [LC3_AW-1:0] LC3_RESET_PC = 16'h3000;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [LC3_AW-1:0] pc;
    logic [LC3_DW-1:0] inst;
  } fetch_entry_t;

  // Request handshake state: no request, live request, request whose data will be dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Entry storage; cleared on reset so the head reads as zero before the first fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PW'(i)] <= '0;
      end
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy; flush empties the queue and overrides push and pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch unit: owns the fetch PC, keeps up to DEPTH instructions
// ahead of decode and runs a single-outstanding req/ack memory handshake.
// Optional feature macro: FETCH_BYPASS_EN (ack data presented to decode in the
// same cycle when the queue is empty).
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned    AW       = LC3_AW,
  parameter int unsigned    DW       = LC3_DW,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = AW'(LC3_RESET_PC)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          br_taken,
  input  logic [AW-1:0] taddr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic [AW-1:0] inst_npc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [AW-1:0] fpc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          ack_ok_c;
  logic          q_valid_c;
  logic          bypass_c;
  logic          push_c;
  logic          pop_c;

  // A live (non-dropped) response this cycle.
  assign ack_ok_c  = (state == REQ) && imem_ack && !br_taken;
  assign q_valid_c = (count != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_c = ack_ok_c && !q_valid_c;
`else
  assign bypass_c = 1'b0;
`endif

  // Decode-facing head: queue head, or the arriving response when bypassing.
  assign inst_valid = q_valid_c || bypass_c;
  assign inst       = bypass_c ? imem_rdata : DW'(head.inst);
  assign inst_pc    = bypass_c ? imem_addr : AW'(head.pc);
  assign inst_npc   = inst_pc + AW'(1);

  // A bypassed response consumed by decode never enters the queue; a redirect cancels both sides.
  assign push_c     = ack_ok_c && !(bypass_c && inst_ready);
  assign pop_c      = q_valid_c && inst_ready && !br_taken;
  assign push_entry = '{pc: LC3_AW'(imem_addr), inst: LC3_DW'(imem_rdata)};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (br_taken),
    .push       (push_c),
    .push_entry (push_entry),
    .pop        (pop_c),
    .count      (count),
    .head       (head)
  );

  // Request FSM with registered req/addr; redirect retargets fpc and orphans any live request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fpc       <= RESET_PC;
    end else if (br_taken) begin
      fpc <= taddr;
      if ((state != IDLE) && imem_ack) begin
        state    <= IDLE;
        imem_req <= 1'b0;
      end else if (state == REQ) begin
        state <= DROP;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count < CW'(DEPTH)) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fpc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            fpc      <= fpc + AW'(1);
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: directed scenarios plus a randomized
// run against a transaction-level model (expected PC stream and queue occupancy).
module tb_fetch_prefetch;

  localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_npc;

  int vectors = 0;
  int miscompares = 0;

  // Memory responder state
  bit          mem_busy = 1'b0;
  int unsigned mem_wait = 0;
  logic [15:0] mem_addr = '0;
  bit          new_req = 1'b0;

  fetch_prefetch #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .br_taken   (br_taken),
    .taddr      (taddr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_npc   (inst_npc)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[3:0], a[15:4]} ^ 16'h5A3C;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Memory: accepts a new request when idle, answers after 0..maxlat wait cycles.
  task automatic mem_drive(input int unsigned maxlat);
    imem_ack = 1'b0;
    new_req  = 1'b0;
    if (!mem_busy && imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_wait = $urandom_range(maxlat, 0);
      new_req  = 1'b1;
    end
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mdata(mem_addr);
        mem_busy   = 1'b0;
      end else begin
        mem_wait--;
      end
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; br_taken = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    mem_busy = 1'b0;
    new_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; br_taken = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    tick;
    tick;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%h exp=0", imem_req); end
    vectors++; if (imem_addr !== 16'h3000) begin miscompares++; $display("FAIL reset_addr got=%h exp=3000", imem_addr); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%h exp=0", inst_valid); end
    vectors++; if (inst !== 16'h0000) begin miscompares++; $display("FAIL reset_inst got=%h exp=0000", inst); end
    vectors++; if (inst_pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc got=%h exp=0000", inst_pc); end
    vectors++; if (inst_npc !== 16'h0001) begin miscompares++; $display("FAIL reset_npc got=%h exp=0001", inst_npc); end
    reset = 1'b0;
    tick;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got=%h exp=1", imem_req); end
    vectors++; if (imem_addr !== 16'h3000) begin miscompares++; $display("FAIL first_addr got=%h exp=3000", imem_addr); end
  endtask

  task automatic test_stream;
    logic [15:0] exp_pc;
    logic [15:0] exp_req;
    int hs;
    bit first_ack;
    do_reset;
    exp_pc = 16'h3000; exp_req = 16'h3000; hs = 0; first_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick;
      mem_drive(0);
      inst_ready = 1'b1;
      #1;
      if (imem_ack && !first_ack) begin
        first_ack = 1'b1;
        vectors++; if (inst_valid !== BYP) begin miscompares++; $display("FAIL stream_ack_latency got=%h exp=%h", inst_valid, BYP); end
      end
      if (new_req) begin
        vectors++; if (imem_addr !== exp_req) begin miscompares++; $display("FAIL stream_req_addr got=%h exp=%h", imem_addr, exp_req); end
        exp_req++;
      end
      if (inst_valid && inst_ready) begin
        vectors++;
        if (inst_pc !== exp_pc || inst !== mdata(exp_pc) || inst_npc !== exp_pc + 16'd1) begin
          miscompares++; $display("FAIL stream_head got=%h/%h/%h exp=%h/%h/%h", inst_pc, inst, inst_npc, exp_pc, mdata(exp_pc), exp_pc + 16'd1);
        end
        exp_pc++;
        hs++;
      end
    end
    vectors++; if (hs < 19) begin miscompares++; $display("FAIL stream_rate got=%0d exp>=19", hs); end
  endtask

  task automatic test_full;
    int reqs;
    int got_idx;
    logic [15:0] got_addr;
    do_reset;
    inst_ready = 1'b0; reqs = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      mem_drive(0);
      #1;
      if (new_req) begin
        vectors++; if (imem_addr !== 16'h3000 + 16'(reqs)) begin miscompares++; $display("FAIL full_req_addr got=%h exp=%h", imem_addr, 16'h3000 + 16'(reqs)); end
        reqs++;
      end
    end
    vectors++; if (reqs != DEPTH) begin miscompares++; $display("FAIL full_req_count got=%0d exp=%0d", reqs, DEPTH); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL full_req_idle got=%h exp=0", imem_req); end
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 16'h3000) begin miscompares++; $display("FAIL full_head got=%h/%h exp=1/3000", inst_valid, inst_pc); end
    tick;
    mem_drive(0);
    inst_ready = 1'b1;
    #1;
    got_idx = -1; got_addr = '0;
    for (int c = 0; c < 6; c++) begin
      tick;
      inst_ready = 1'b0;
      mem_drive(0);
      #1;
      if (new_req && got_idx < 0) begin got_idx = c; got_addr = imem_addr; end
    end
    vectors++;
    if (got_idx != 1 || got_addr !== 16'h3004) begin
      miscompares++; $display("FAIL full_resume got=%0d/%h exp=1/3004", got_idx, got_addr);
    end
  endtask

  task automatic test_branch_drop;
    bit found;
    bit got_req;
    bit got_hs;
    do_reset;
    inst_ready = 1'b0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick;
      if (imem_req && imem_addr == 16'h3002) begin
        found = 1'b1;
        imem_ack = 1'b0;
      end else begin
        mem_drive(0);
        #1;
      end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL drop_wait_3002 got=timeout exp=req"); end
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL drop_pre_valid got=%h exp=1", inst_valid); end
    br_taken = 1'b1; taddr = 16'h3100;
    #1;
    tick;
    br_taken = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL drop_flush_valid got=%h exp=0", inst_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h3002) begin miscompares++; $display("FAIL drop_hold got=%h/%h exp=1/3002", imem_req, imem_addr); end
    tick;
    tick;
    imem_ack = 1'b1; imem_rdata = mdata(16'h3002);
    #1;
    tick;
    imem_ack = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL drop_stale got=%h/%h exp=0/0", imem_req, inst_valid); end
    mem_busy = 1'b0; inst_ready = 1'b1; got_req = 1'b0; got_hs = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick;
      mem_drive(0);
      #1;
      if (new_req && !got_req) begin
        got_req = 1'b1;
        vectors++; if (imem_addr !== 16'h3100) begin miscompares++; $display("FAIL drop_next_req got=%h exp=3100", imem_addr); end
      end
      if (inst_valid && inst_ready && !got_hs) begin
        got_hs = 1'b1;
        vectors++; if (inst_pc !== 16'h3100 || inst !== mdata(16'h3100)) begin miscompares++; $display("FAIL drop_first_inst got=%h/%h exp=3100/%h", inst_pc, inst, mdata(16'h3100)); end
      end
    end
    vectors++; if (!got_req || !got_hs) begin miscompares++; $display("FAIL drop_resume got=%0d/%0d exp=1/1", got_req, got_hs); end
  endtask

  task automatic test_branch_ack_pop;
    bit found;
    bit got_hs;
    do_reset;
    inst_ready = 1'b0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick;
      if (imem_req && imem_addr == 16'h3001) begin
        found = 1'b1;
      end else begin
        mem_drive(0);
        #1;
      end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL coinc_wait_3001 got=timeout exp=req"); end
    imem_ack = 1'b1; imem_rdata = mdata(16'h3001); inst_ready = 1'b1;
    br_taken = 1'b1; taddr = 16'h3100;
    #1;
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 16'h3000) begin miscompares++; $display("FAIL coinc_pre_head got=%h/%h exp=1/3000", inst_valid, inst_pc); end
    tick;
    imem_ack = 1'b0; br_taken = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL coinc_after got=%h/%h exp=0/0", inst_valid, imem_req); end
    tick;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h3100) begin miscompares++; $display("FAIL coinc_next_req got=%h/%h exp=1/3100", imem_req, imem_addr); end
    mem_busy = 1'b0; got_hs = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      mem_drive(0);
      #1;
      if (inst_valid && inst_ready && !got_hs) begin
        got_hs = 1'b1;
        vectors++; if (inst_pc !== 16'h3100 || inst !== mdata(16'h3100)) begin miscompares++; $display("FAIL coinc_first_inst got=%h/%h exp=3100/%h", inst_pc, inst, mdata(16'h3100)); end
      end
    end
    vectors++; if (!got_hs) begin miscompares++; $display("FAIL coinc_resume got=timeout exp=inst"); end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_pc;
    logic [15:0] exp_req;
    int hs;
    do_reset;
    br_taken = 1'b1; taddr = 16'hFFFE; inst_ready = 1'b1;
    exp_pc = 16'hFFFE; exp_req = 16'hFFFE; hs = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      br_taken = 1'b0;
      mem_drive(0);
      #1;
      if (new_req) begin
        vectors++; if (imem_addr !== exp_req) begin miscompares++; $display("FAIL wrap_req_addr got=%h exp=%h", imem_addr, exp_req); end
        exp_req++;
      end
      if (inst_valid && inst_ready) begin
        vectors++;
        if (inst_pc !== exp_pc || inst !== mdata(exp_pc) || inst_npc !== exp_pc + 16'd1) begin
          miscompares++; $display("FAIL wrap_head got=%h/%h/%h exp=%h/%h/%h", inst_pc, inst, inst_npc, exp_pc, mdata(exp_pc), exp_pc + 16'd1);
        end
        exp_pc++;
        hs++;
      end
    end
    vectors++; if (hs < 3) begin miscompares++; $display("FAIL wrap_count got=%0d exp>=3", hs); end
  endtask

  task automatic test_reset_drop;
    bit got_hs;
    do_reset;
    inst_ready = 1'b0;
    tick;
    br_taken = 1'b1; taddr = 16'h3100;
    #1;
    tick;
    br_taken = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h3000) begin miscompares++; $display("FAIL rstdrop_hold got=%h/%h exp=1/3000", imem_req, imem_addr); end
    reset = 1'b1;
    tick;
    vectors++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 16'h3000) begin miscompares++; $display("FAIL rstdrop_in_reset got=%h/%h/%h exp=0/0/3000", imem_req, inst_valid, imem_addr); end
    tick;
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = ~mdata(16'h3000);
    #1;
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rstdrop_stale_valid got=%h exp=0", inst_valid); end
    tick;
    imem_ack = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h3000 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL rstdrop_first_req got=%h/%h/%h exp=1/3000/0", imem_req, imem_addr, inst_valid); end
    mem_busy = 1'b0; inst_ready = 1'b1; got_hs = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      mem_drive(0);
      #1;
      if (inst_valid && inst_ready && !got_hs) begin
        got_hs = 1'b1;
        vectors++; if (inst_pc !== 16'h3000 || inst !== mdata(16'h3000)) begin miscompares++; $display("FAIL rstdrop_first_inst got=%h/%h exp=3000/%h", inst_pc, inst, mdata(16'h3000)); end
      end
    end
    vectors++; if (!got_hs) begin miscompares++; $display("FAIL rstdrop_resume got=timeout exp=inst"); end
  endtask

  task automatic test_random;
    logic [15:0] exp_pc;
    logic [15:0] exp_req;
    int occ;
    bit stale;
    bit hs;
    do_reset;
    exp_pc = 16'h3000; exp_req = 16'h3000; occ = 0; stale = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick;
      mem_drive(3);
      inst_ready = ($urandom_range(3, 0) != 0);
      br_taken   = ($urandom_range(24, 0) == 0);
      taddr      = ($urandom_range(3, 0) == 0) ? 16'hFFFD : 16'($urandom);
      #1;
`ifndef FETCH_BYPASS_EN
      vectors++; if (inst_valid !== (occ > 0)) begin miscompares++; $display("FAIL rand_valid cyc=%0d got=%h exp=%h", c, inst_valid, (occ > 0)); end
`endif
      if (new_req) begin
        vectors++;
        if (imem_addr !== exp_req || occ >= int'(DEPTH)) begin
          miscompares++; $display("FAIL rand_req cyc=%0d got=%h occ=%0d exp=%h occ<%0d", c, imem_addr, occ, exp_req, DEPTH);
        end
        exp_req++;
      end
      hs = inst_valid && inst_ready && !br_taken;
      if (hs) begin
        vectors++;
        if (inst_pc !== exp_pc || inst !== mdata(exp_pc) || inst_npc !== exp_pc + 16'd1) begin
          miscompares++; $display("FAIL rand_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", c, inst_pc, inst, inst_npc, exp_pc, mdata(exp_pc), exp_pc + 16'd1);
        end
        exp_pc++;
      end
      if (br_taken) begin
        occ = 0; exp_pc = taddr; exp_req = taddr; stale = mem_busy;
      end else begin
        if (imem_ack) begin
          if (!stale) occ++;
          stale = 1'b0;
        end
        if (hs) occ--;
      end
    end
    br_taken = 1'b0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_full;
    test_branch_drop;
    test_branch_ack_pop;
    test_wrap;
    test_reset_drop;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
